// File: rtl/voiceprint_pkg.sv
// voiceprint_pkg: shared FSM/message encodings and ASCII constants for the result reporter.
package voiceprint_pkg;
    typedef enum logic {IDLE, SEND} state_e;
    typedef enum logic {MSG_RES, MSG_TRN} msg_e;

    localparam logic [7:0] ASC_I     = 8'h49;
    localparam logic [7:0] ASC_D     = 8'h44;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_T     = 8'h54;
    localparam logic [7:0] ASC_R     = 8'h52;
    localparam logic [7:0] ASC_N     = 8'h4E;
    localparam logic [7:0] ASC_X     = 8'h58;
    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;

    localparam logic [2:0] MSG_LEN_RES = 3'd6;
    localparam logic [2:0] MSG_LEN_TRN = 3'd5;

    function automatic logic [2:0] msg_last_idx(input msg_e t);
        return (t == MSG_TRN) ? MSG_LEN_TRN - 3'd1 : MSG_LEN_RES - 3'd1;
    endfunction
endpackage

// File: rtl/vp_msg_rom.sv
// vp_msg_rom: combinational message byte lookup for RESULT ("ID:C\r\n") and TRAIN ("TRN\r\n").
module vp_msg_rom
    import voiceprint_pkg::*;
#(
    parameter logic [2:0] NO_MATCH_CODE = 3'd7
) (
    input  msg_e       msg_type_i,
    input  logic [2:0] idx_i,
    input  logic [2:0] val_i,
    output logic [7:0] data_o
);
    logic [7:0] code;

    always_comb begin
        code   = (val_i == NO_MATCH_CODE) ? ASC_X : ASC_0 + {5'd0, val_i};
        data_o = 8'h00;
        if (msg_type_i == MSG_TRN) begin
            case (idx_i)
                3'd0:    data_o = ASC_T;
                3'd1:    data_o = ASC_R;
                3'd2:    data_o = ASC_N;
                3'd3:    data_o = ASC_CR;
                3'd4:    data_o = ASC_LF;
                default: data_o = 8'h00;
            endcase
        end else begin
            case (idx_i)
                3'd0:    data_o = ASC_I;
                3'd1:    data_o = ASC_D;
                3'd2:    data_o = ASC_COLON;
                3'd3:    data_o = code;
                3'd4:    data_o = ASC_CR;
                3'd5:    data_o = ASC_LF;
                default: data_o = 8'h00;
            endcase
        end
    end
endmodule

// File: rtl/voiceprint_result_reporter.sv
// voiceprint_result_reporter: captures recognition/training events and streams them
// as ASCII messages over a valid/ready byte interface to the UART TX.
module voiceprint_result_reporter
    import voiceprint_pkg::*;
#(
    parameter logic [2:0] NO_MATCH_CODE = 3'd7,
    parameter int         CNT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           recognition_result,
    input  logic                 recognition_result_flag,
    input  logic                 train_down,
    input  logic                 tx_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    output logic                 busy,
    output logic [2:0]           last_result,
    output logic                 last_result_valid,
    output logic [CNT_WIDTH-1:0] dropped_cnt
);
    state_e               state_q, state_d;
    msg_e                 type_q, type_d;
    logic [2:0]           idx_q, idx_d;
    logic [2:0]           msg_val_q, msg_val_d;
    logic                 pend_res_q, pend_res_d;
    logic [2:0]           pend_val_q, pend_val_d;
    logic                 pend_trn_q, pend_trn_d;
    logic                 train_q;
    logic [2:0]           last_q, last_d;
    logic                 last_valid_q;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;
    logic                 take_res, take_trn;
    logic [7:0]           rom_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            type_q       <= MSG_RES;
            idx_q        <= '0;
            msg_val_q    <= '0;
            pend_res_q   <= 1'b0;
            pend_val_q   <= '0;
            pend_trn_q   <= 1'b0;
            train_q      <= 1'b0;
            last_q       <= '0;
            last_valid_q <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            type_q       <= type_d;
            idx_q        <= idx_d;
            msg_val_q    <= msg_val_d;
            pend_res_q   <= pend_res_d;
            pend_val_q   <= pend_val_d;
            pend_trn_q   <= pend_trn_d;
            train_q      <= train_down;
            last_q       <= last_d;
            last_valid_q <= last_valid_q | recognition_result_flag;
            drop_q       <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        idx_d     = idx_q;
        msg_val_d = msg_val_q;
        take_res  = 1'b0;
        take_trn  = 1'b0;
        if (state_q == IDLE) begin
            if (pend_trn_q) begin
                take_trn = 1'b1;
                type_d   = MSG_TRN;
                idx_d    = '0;
                state_d  = SEND;
            end else if (pend_res_q) begin
                take_res  = 1'b1;
                type_d    = MSG_RES;
                msg_val_d = pend_val_q;
                idx_d     = '0;
                state_d   = SEND;
            end
        end else if (tx_ready) begin
            idx_d = idx_q + 3'd1;
            if (idx_q == msg_last_idx(type_q))
                state_d = IDLE;
        end
        // A new flag in the consuming cycle refills pending rather than dropping.
        pend_trn_d = (train_down & ~train_q) | (pend_trn_q & ~take_trn);
        pend_res_d = recognition_result_flag | (pend_res_q & ~take_res);
        pend_val_d = recognition_result_flag ? recognition_result : pend_val_q;
        last_d     = recognition_result_flag ? recognition_result : last_q;
        drop_d     = (recognition_result_flag & pend_res_q & ~take_res & ~&drop_q)
                     ? drop_q + CNT_WIDTH'(1) : drop_q;
    end

    vp_msg_rom #(.NO_MATCH_CODE(NO_MATCH_CODE)) u_rom (
        .msg_type_i (type_q),
        .idx_i      (idx_q),
        .val_i      (msg_val_q),
        .data_o     (rom_data)
    );

    assign tx_valid          = (state_q == SEND);
    assign tx_data           = tx_valid ? rom_data : 8'h00;
    assign busy              = tx_valid | pend_res_q | pend_trn_q;
    assign last_result       = last_q;
    assign last_result_valid = last_valid_q;
    assign dropped_cnt       = drop_q;
endmodule

// File: tb/tb_voiceprint_result_reporter.sv
// tb_voiceprint_result_reporter: directed + randomized bench against a message-queue
// reference model of the reporter.
module tb_voiceprint_result_reporter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] recognition_result = '0;
    logic       recognition_result_flag = 1'b0;
    logic       train_down = 1'b0;
    logic       tx_ready = 1'b0;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       busy;
    logic [2:0] last_result;
    logic       last_result_valid;
    logic [7:0] dropped_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model: the message in flight is a byte queue, pendings are plain flags.
    logic [7:0] m_cur[$];
    bit         m_pres, m_ptrn, m_trn_prev, m_lvalid;
    logic [2:0] m_pval, m_last;
    int         m_drop;
    logic [7:0] log_q[$];

    voiceprint_result_reporter dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .recognition_result      (recognition_result),
        .recognition_result_flag (recognition_result_flag),
        .train_down              (train_down),
        .tx_ready                (tx_ready),
        .tx_valid                (tx_valid),
        .tx_data                 (tx_data),
        .busy                    (busy),
        .last_result             (last_result),
        .last_result_valid       (last_result_valid),
        .dropped_cnt             (dropped_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_cur.delete();
        m_pres = 0; m_ptrn = 0; m_trn_prev = 0; m_lvalid = 0;
        m_pval = 0; m_last = 0; m_drop = 0;
    endtask

    task automatic model_edge();
        bit idle, take_t, take_r, rise;
        logic [7:0] c;
        idle   = (m_cur.size() == 0);
        take_t = idle && m_ptrn;
        take_r = idle && !m_ptrn && m_pres;
        rise   = train_down && !m_trn_prev;
        if (recognition_result_flag && m_pres && !take_r && m_drop < 255) m_drop++;
        if (!idle && tx_ready) void'(m_cur.pop_front());
        c = (m_pval == 3'd7) ? 8'h58 : 8'h30 + {5'd0, m_pval};
        if (take_t) m_cur = {8'h54, 8'h52, 8'h4E, 8'h0D, 8'h0A};
        else if (take_r) m_cur = {8'h49, 8'h44, 8'h3A, c, 8'h0D, 8'h0A};
        m_ptrn = rise || (m_ptrn && !take_t);
        m_pres = recognition_result_flag || (m_pres && !take_r);
        if (recognition_result_flag) begin
            m_pval = recognition_result; m_last = recognition_result; m_lvalid = 1;
        end
        m_trn_prev = train_down;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, tx_valid, m_cur.size() != 0);
        if (m_cur.size() != 0) chk({tag, ".data"}, tx_data, m_cur[0]);
        chk({tag, ".busy"}, busy, (m_cur.size() != 0) || m_pres || m_ptrn);
        chk({tag, ".last"}, last_result, m_last);
        chk({tag, ".lvalid"}, last_result_valid, m_lvalid);
        chk({tag, ".drop"}, dropped_cnt, m_drop);
    endtask

    task automatic step(input bit f, input logic [2:0] r, input bit t, input bit rdy);
        recognition_result_flag = f;
        recognition_result = r;
        train_down = t;
        tx_ready = rdy;
        if (tx_valid && rdy) log_q.push_back(tx_data);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all("step");
    endtask

    task automatic idle_steps(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 3'd0, 0, rdy);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid"}, tx_valid, 0);
        chk({tag, ".data"}, tx_data, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".last"}, last_result, 0);
        chk({tag, ".lvalid"}, last_result_valid, 0);
        chk({tag, ".drop"}, dropped_cnt, 0);
    endtask

    initial begin
        logic [7:0] exp_res[6];
        logic [7:0] exp_trn[5];
        int d0;
        exp_res = '{8'h49, 8'h44, 8'h3A, 8'h33, 8'h0D, 8'h0A};
        exp_trn = '{8'h54, 8'h52, 8'h4E, 8'h0D, 8'h0A};
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all("post_reset");

        // Result 3 with latency check
        step(1, 3'd3, 0, 1);
        chk("lat.n1", tx_valid, 0);
        step(0, 3'd0, 0, 1);
        chk("lat.n2", tx_valid, 1);
        chk("lat.n2.data", tx_data, 8'h49);
        log_q.delete();
        idle_steps(10, 1);
        chk("res3.len", log_q.size(), 6);
        for (int i = 0; i < 6 && i < log_q.size(); i++) chk("res3.byte", log_q[i], exp_res[i]);
        chk("res3.last", last_result, 3);
        chk("res3.lvalid", last_result_valid, 1);

        // No-match code and held train_down
        log_q.delete();
        step(1, 3'd7, 0, 1);
        idle_steps(10, 1);
        chk("nomatch.len", log_q.size(), 6);
        if (log_q.size() == 6) chk("nomatch.X", log_q[3], 8'h58);
        log_q.delete();
        for (int i = 0; i < 15; i++) step(0, 3'd0, 1, 1);
        idle_steps(3, 1);
        chk("trn.len", log_q.size(), 5);
        for (int i = 0; i < 5 && i < log_q.size(); i++) chk("trn.byte", log_q[i], exp_trn[i]);

        // Random events with random back-pressure
        for (int i = 0; i < 300; i++)
            step($urandom_range(5) == 0, 3'($urandom), $urandom_range(7) < 2, 1'($urandom));
        idle_steps(30, 1);

        // Stalled message is not altered by new results; latest pending wins
        d0 = m_drop;
        step(1, 3'd4, 0, 0);
        idle_steps(3, 0);
        step(1, 3'd1, 0, 0);
        step(1, 3'd2, 0, 0);
        step(1, 3'd5, 0, 0);
        chk("stall.data", tx_data, 8'h49);
        log_q.delete();
        idle_steps(20, 1);
        chk("stall.len", log_q.size(), 12);
        if (log_q.size() == 12) begin
            chk("stall.first", log_q[3], 8'h34);
            chk("stall.second", log_q[9], 8'h35);
        end
        chk("stall.drop", dropped_cnt, (d0 + 2 > 255) ? 255 : d0 + 2);

        // Simultaneous result and train edge: TRAIN first, gap, RESULT
        log_q.delete();
        step(1, 3'd6, 1, 1);
        idle_steps(20, 1);
        chk("simul.len", log_q.size(), 11);
        if (log_q.size() == 11) begin
            chk("simul.trn", log_q[0], 8'h54);
            chk("simul.res", log_q[5], 8'h49);
            chk("simul.code", log_q[8], 8'h36);
        end

        // Saturating drop counter
        step(1, 3'd0, 0, 0);
        for (int i = 0; i < 270; i++) step(1, 3'($urandom), 0, 0);
        chk("sat.drop", dropped_cnt, 8'hFF);
        idle_steps(20, 1);
        chk("sat.hold", dropped_cnt, 8'hFF);

        // Asynchronous reset mid-message at byte 3
        step(1, 3'd2, 0, 1);
        idle_steps(4, 1);
        chk("mid.byte3", tx_data, 8'h32);
        #2;
        rst_n = 1'b0;
        recognition_result_flag = 1'b0;
        train_down = 1'b0;
        #1;
        check_zero("async_rst");
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        log_q.delete();
        idle_steps(12, 1);
        chk("after_rst.len", log_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
